bias_bank_pingpong: RTL and testbench
=====================================

BIAS_BANK_PINGPONG -- requirements
Module: bias_bank_pingpong

Interface
REQ-001 Parameter SA_ROW_NUM, default 4: number of SA rows, i.e. channel groups presented per read.
REQ-002 Parameter ROW_NUM, default 16: rows per SA; bank depth N = SA_ROW_NUM*ROW_NUM (64).
REQ-003 Parameter BIAS_WIDTH, default 8: mode-0 bias width.
REQ-004 Parameter PAR_W, default 2: mode-1 entry width is E = BIAS_WIDTH*PAR_W (16).
REQ-005 Parameter WORD_LEN, default 512: load word width.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 cmd_valid/cmd_ready  input/output  1/1  load-command handshake.
REQ-009 cmd_mode  input  1  0: BIAS_WIDTH-bit entries packed in the word; 1: E-bit entries packed.
REQ-010 cmd_start, cmd_size  input  8/8  first entry index; number of entries to load.
REQ-011 word_valid/word_ready  input/output  1/1  bias-word stream handshake.
REQ-012 bias_word  input  WORD_LEN  packed bias data.
REQ-013 load_done  output  1  one-cycle pulse after the last entry is written to the shadow bank.
REQ-014 swap  input  1  request to exchange the active and shadow banks.
REQ-015 active_bank  output  1  index of the bank currently driving reads.
REQ-016 out_sa_row_idx  input  6  read row, 1..ROW_NUM; 0 means "no row".
REQ-017 bias_sets  output  SA_ROW_NUM*E  entry[(g*ROW_NUM)+idx-1] of the active bank in slice g (g=0 in the LSBs).

Function
REQ-018 The block SHALL hold two banks of N E-bit entries: reads use the active bank, loads write only the shadow bank.
REQ-019 The FSM SHALL have states IDLE, LOAD and DONE; cmd_ready=1 only in IDLE.
REQ-020 On a cmd handshake the block SHALL latch mode, start and end = min(start+size, N), with the end computed at 9 bits so it does not wrap, and enter LOAD; if end<=start it SHALL go directly to DONE without consuming words.
REQ-021 Entries per word SHALL be P = WORD_LEN/BIAS_WIDTH (mode 0) or WORD_LEN/E (mode 1); word_ready=1 only in LOAD.
REQ-022 On each word handshake the block SHALL write entries start+k*P+s, s=0..P-1, restricted to entries below end, taking bias_word slot s, where k counts the words accepted so far in this load.
REQ-023 A mode-0 entry SHALL occupy bits [BIAS_WIDTH-1:0]; its upper bits follow REQ-034/035.
REQ-024 When the word covering end-1 is accepted, the FSM SHALL enter DONE; in DONE load_done=1 for one cycle, then the FSM returns to IDLE.
REQ-025 A swap asserted in IDLE or DONE SHALL toggle active_bank on that edge.
REQ-026 A swap asserted during LOAD SHALL be latched and applied on the edge that enters DONE; multiple swaps during one LOAD count as one.
REQ-027 When swap and load_done coincide, the bank toggles exactly once.
REQ-028 bias_sets SHALL be registered, with 1-cycle latency from out_sa_row_idx and active_bank; idx 0 or idx>ROW_NUM SHALL produce all zeros.
REQ-029 Shadow entries outside [start,end) SHALL keep their previous values.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, active_bank=0, latched swap cleared, load_done=0, bias_sets=0.
REQ-031 On rst_n=0, asynchronously: both banks cleared to 0.
REQ-032 On rst_n=0, asynchronously: cmd_ready=1 and word_ready=0 once reset is released.
REQ-033 A reset during LOAD SHALL abort the load; no partial-load state survives.

Configuration
REQ-034 With BIAS_SIGN_EXT_EN defined, mode-0 entries SHALL be sign-extended from BIAS_WIDTH to E bits.
REQ-035 Without BIAS_SIGN_EXT_EN, mode-0 entries SHALL be zero-extended; mode 1 is unaffected either way.

Verification
REQ-036 Mode 0, start=0, size=64, one word with byte i=i, then swap, idx=1 -> one cycle later bias_sets={0x0030,0x0020,0x0010,0x0000}; load_done pulses once.
REQ-037 Mode 1, start=0, size=64 -> exactly two words consumed (32 entries each); idx=16 yields entries 63/47/31/15 from the second/second/first/first word.
REQ-038 Mode 0, start=60, size=10 -> the end is clamped to 64; one word writes entries 60..63 from slots 0..3; entries 0..59 are unchanged.
REQ-039 A swap pulse mid-LOAD -> active_bank toggles exactly on the DONE-entry edge; reads before that still show the old bank.
REQ-040 Byte 0x80 loaded in mode 0 -> entry reads 0xFF80 with BIAS_SIGN_EXT_EN and 0x0080 without it; rst_n low mid-LOAD -> all outputs zero and FSM in IDLE.

Source files
------------

// File: rtl/bias_bank_pingpong.sv
// bias_bank_pingpong: two-bank bias store; loads fill the shadow bank while reads come from the active bank.
// Optional BIAS_SIGN_EXT_EN: sign-extend mode-0 entries instead of zero-extending them.
module bias_bank_pingpong #(
    parameter int SA_ROW_NUM = 4,
    parameter int ROW_NUM    = 16,
    parameter int BIAS_WIDTH = 8,
    parameter int PAR_W      = 2,
    parameter int WORD_LEN   = 512
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic                                   cmd_mode,
    input  logic [7:0]                             cmd_start,
    input  logic [7:0]                             cmd_size,
    input  logic                                   word_valid,
    output logic                                   word_ready,
    input  logic [WORD_LEN-1:0]                    bias_word,
    output logic                                   load_done,
    input  logic                                   swap,
    output logic                                   active_bank,
    input  logic [5:0]                             out_sa_row_idx,
    output logic [SA_ROW_NUM*BIAS_WIDTH*PAR_W-1:0] bias_sets
);
    localparam int N  = SA_ROW_NUM * ROW_NUM;
    localparam int E  = BIAS_WIDTH * PAR_W;
    localparam int P0 = WORD_LEN / BIAS_WIDTH;
    localparam int P1 = WORD_LEN / E;
    localparam int AW = $clog2(N);
    localparam int WW = $clog2(WORD_LEN);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
`ifdef BIAS_SIGN_EXT_EN
    localparam logic SIGN_EXT = 1'b1;
`else
    localparam logic SIGN_EXT = 1'b0;
`endif

    logic [1:0]              state_q, state_d;
    logic                    mode_q, mode_d, swap_pend_q, swap_pend_d, active_q, active_d;
    logic [8:0]              base_q, base_d, end_q, end_d, cmd_sum, cmd_end, step;
    logic                    cmd_hs, word_hs, enter_done;
    logic [SA_ROW_NUM*E-1:0] bias_sets_q, bias_sets_d;
    logic [E-1:0]            bank_q [2][N];
    logic [E-1:0]            wr_data [N];
    logic [N-1:0]            wr_mask;
    logic [BIAS_WIDTH-1:0]   narrow;
    int                      s;

    assign cmd_ready   = state_q == IDLE;
    assign word_ready  = state_q == LOAD;
    assign load_done   = state_q == DONE;
    assign active_bank = active_q;
    assign bias_sets   = bias_sets_q;

    always_comb begin
        cmd_hs      = cmd_valid && state_q == IDLE;
        word_hs     = word_valid && state_q == LOAD;
        step        = mode_q ? 9'(P1) : 9'(P0);
        cmd_sum     = {1'b0, cmd_start} + {1'b0, cmd_size};
        cmd_end     = (cmd_sum > 9'(N)) ? 9'(N) : cmd_sum;
        enter_done  = word_hs && (base_q + step >= end_q);
        state_d     = (state_q == IDLE) ? (cmd_valid ? ((cmd_end <= {1'b0, cmd_start}) ? DONE : LOAD) : IDLE)
                    : (state_q == LOAD) ? (enter_done ? DONE : LOAD) : IDLE;
        mode_d      = cmd_hs ? cmd_mode : mode_q;
        base_d      = cmd_hs ? {1'b0, cmd_start} : word_hs ? base_q + step : base_q;
        end_d       = cmd_hs ? cmd_end : end_q;
        // swaps seen during a load are held and applied once, on the edge that finishes it
        swap_pend_d = (state_q == LOAD) && !enter_done && (swap_pend_q || swap);
        active_d    = active_q ^ ((state_q == LOAD) ? (enter_done && (swap_pend_q || swap)) : swap);
        narrow      = '0;
        s           = 0;
        for (int j = 0; j < N; j++) begin
            s          = j - int'(base_q);
            wr_mask[j] = word_hs && j >= int'(base_q) && j < int'(end_q) && s < (mode_q ? P1 : P0);
            wr_data[j] = '0;
            if (wr_mask[j]) begin
                narrow     = bias_word[WW'(s * BIAS_WIDTH) +: BIAS_WIDTH];
                wr_data[j] = mode_q ? bias_word[WW'(s * E) +: E]
                                    : {{(E - BIAS_WIDTH){SIGN_EXT & narrow[BIAS_WIDTH-1]}}, narrow};
            end
        end
        bias_sets_d = '0;
        for (int g = 0; g < SA_ROW_NUM; g++) begin
            if (out_sa_row_idx != 6'd0 && int'(out_sa_row_idx) <= ROW_NUM)
                bias_sets_d[g*E +: E] = bank_q[active_q][AW'(g * ROW_NUM + int'(out_sa_row_idx) - 1)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            base_q      <= '0;
            end_q       <= '0;
            swap_pend_q <= 1'b0;
            active_q    <= 1'b0;
            bias_sets_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            base_q      <= base_d;
            end_q       <= end_d;
            swap_pend_q <= swap_pend_d;
            active_q    <= active_d;
            bias_sets_q <= bias_sets_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int j = 0; j < N; j++)
                    bank_q[b][j] <= '0;
        end else begin
            for (int j = 0; j < N; j++)
                if (wr_mask[j]) bank_q[~active_q][j] <= wr_data[j];
        end
    end
endmodule

// File: tb/tb_bias_bank_pingpong.sv
// tb_bias_bank_pingpong: directed loads/swaps/reads checked against a bank-array model every cycle.
module tb_bias_bank_pingpong;
    logic         clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_mode = 1'b0, word_valid = 1'b0, swap = 1'b0;
    logic [7:0]   cmd_start = '0, cmd_size = '0;
    logic [511:0] bias_word = '0;
    logic [5:0]   out_sa_row_idx = '0;
    logic         cmd_ready, word_ready, load_done, active_bank;
    logic [63:0]  bias_sets;
    logic [15:0]  mb [2][64];
    logic         m_act = 1'b0;
    logic [63:0]  exp_sets = '0;
    int           n_chk = 0, n_fail = 0;

    bias_bank_pingpong dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_start(cmd_start), .cmd_size(cmd_size), .word_valid(word_valid), .word_ready(word_ready),
        .bias_word(bias_word), .load_done(load_done), .swap(swap), .active_bank(active_bank),
        .out_sa_row_idx(out_sa_row_idx), .bias_sets(bias_sets)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_read(input logic [5:0] idx);
        logic [63:0] r;
        r = '0;
        if (int'(idx) >= 1 && int'(idx) <= 16)
            for (int g = 0; g < 4; g++) r[g*16 +: 16] = mb[m_act][6'(g * 16 + int'(idx) - 1)];
        return r;
    endfunction

    function automatic logic [511:0] mkword(input int seed);
        logic [511:0] w;
        for (int i = 0; i < 64; i++) w[i*8 +: 8] = 8'(seed + i);
        return w;
    endfunction

    function automatic logic [15:0] ent(input logic mode, input logic [511:0] w, input int s);
        logic [7:0] b;
        b = w[9'(s * 8) +: 8];
        if (mode) return w[9'(s * 16) +: 16];
`ifdef BIAS_SIGN_EXT_EN
        return {{8{b[7]}}, b};
`else
        return {8'h00, b};
`endif
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) exp_sets <= '0;
        else exp_sets <= model_read(out_sa_row_idx);

    always @(negedge clk) begin
        chk("active_bank", 64'(active_bank), 64'(m_act));
        chk("bias_sets", bias_sets, exp_sets);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model;
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < 64; j++) mb[b][j] = '0;
    endtask

    task automatic swap_idle;
        swap = 1'b1;
        tick;
        swap = 1'b0;
        m_act = ~m_act;
    endtask

    task automatic sweep;
        for (int i = 0; i < 18; i++) begin
            out_sa_row_idx = 6'(i);
            tick;
        end
        out_sa_row_idx = 6'd63;
        tick;
    endtask

    task automatic do_load(input logic mode, input int start, input int size, input int seed,
                           input int gaps, input logic dswap);
        int p, e, nw, j;
        logic sh;
        logic [511:0] w;
        p  = mode ? 32 : 64;
        e  = (start + size > 64) ? 64 : start + size;
        nw = (e > start) ? (e - start + p - 1) / p : 0;
        sh = ~m_act;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_start = 8'(start); cmd_size = 8'(size);
        tick;
        cmd_valid = 1'b0;
        for (int g = 0; g < gaps; g++) begin
            chk("word_ready_gap", 64'(word_ready), 64'd1);
            swap = 1'b1;
            tick;
            swap = 1'b0;
        end
        for (int k = 0; k < nw; k++) begin
            chk("word_ready_load", 64'(word_ready), 64'd1);
            chk("load_done_busy", 64'(load_done), 64'd0);
            w = mkword(seed + k * 64);
            word_valid = 1'b1; bias_word = w;
            tick;
            word_valid = 1'b0;
            for (int s = 0; s < p; s++) begin
                j = start + k * p + s;
                if (j < e) mb[sh][6'(j)] = ent(mode, w, s);
            end
        end
        if (gaps > 0) m_act = ~m_act;
        chk("load_done_pulse", 64'(load_done), 64'd1);
        chk("word_ready_done", 64'(word_ready), 64'd0);
        chk("cmd_ready_done", 64'(cmd_ready), 64'd0);
        swap = dswap;
        tick;
        swap = 1'b0;
        if (dswap) m_act = ~m_act;
        chk("load_done_clear", 64'(load_done), 64'd0);
        chk("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        clear_model;
        repeat (3) tick;
        chk("rst_bias_sets", bias_sets, 64'd0);
        chk("rst_active", 64'(active_bank), 64'd0);
        chk("rst_load_done", 64'(load_done), 64'd0);
        rst_n = 1'b1;
        tick;
        chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rel_word_ready", 64'(word_ready), 64'd0);

        do_load(1'b0, 0, 64, 0, 0, 1'b0);
        swap_idle;
        out_sa_row_idx = 6'd1;
        tick;
        chk("mode0_full_idx1", bias_sets, 64'h0030_0020_0010_0000);
        sweep;

        do_load(1'b1, 0, 64, 0, 0, 1'b1);
        out_sa_row_idx = 6'd16;
        tick;
        chk("mode1_two_words_idx16", bias_sets, 64'h7F7E_5F5E_3F3E_1F1E);

        do_load(1'b0, 60, 10, 8'h80, 0, 1'b0);
        swap_idle;
        out_sa_row_idx = 6'd13;
        tick;
`ifdef BIAS_SIGN_EXT_EN
        chk("clamp_end_idx13", bias_sets, 64'hFF80_002C_001C_000C);
`else
        chk("clamp_end_idx13", bias_sets, 64'h0080_002C_001C_000C);
`endif
        sweep;

        out_sa_row_idx = 6'd5;
        do_load(1'b0, 0, 32, 8'h10, 2, 1'b0);
        chk("midload_swap_active", 64'(active_bank), 64'd0);
        tick;
        chk("midload_swap_idx5", bias_sets, 64'h6968_4948_0024_0014);

        do_load(1'b0, 10, 0, 0, 0, 1'b0);
        do_load(1'b0, 70, 5, 0, 0, 1'b0);
        do_load(1'b1, 200, 100, 0, 0, 1'b0);

        out_sa_row_idx = 6'd13;
        cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_start = 8'd0; cmd_size = 8'd64;
        tick;
        cmd_valid = 1'b0;
        word_valid = 1'b1; bias_word = mkword(0);
        tick;
        word_valid = 1'b0;
        chk("abort_still_loading", 64'(word_ready), 64'd1);
        chk("abort_pre_read", bias_sets, 64'h7978_5958_002C_001C);
        rst_n = 1'b0;
        m_act = 1'b0;
        clear_model;
        #1;
        chk("abort_bias_sets", bias_sets, 64'd0);
        chk("abort_active", 64'(active_bank), 64'd0);
        chk("abort_load_done", 64'(load_done), 64'd0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_word_ready", 64'(word_ready), 64'd0);
        sweep;

        do_load(1'b0, 0, 64, 8'h80, 0, 1'b0);
        swap_idle;
        out_sa_row_idx = 6'd1;
        tick;
`ifdef BIAS_SIGN_EXT_EN
        chk("byte80_ext", bias_sets, 64'hFFB0_FFA0_FF90_FF80);
`else
        chk("byte80_ext", bias_sets, 64'h00B0_00A0_0090_0080);
`endif
        sweep;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
